// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - CPU, debug and memory signal bundle of the arbiter
interface dm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [2:0]        cpu_type;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_type;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_type,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_type,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_type,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_type,
    output mem_rdata
  );

endinterface

// File: rtl/dm_arb_pick.sv
// rtl/dm_arb_pick.sv - combinational grant picker; DM_ARB_RR_EN selects round-robin ties
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_owner
);

  assign grant_valid = cpu_req | dbg_req;

`ifdef DM_ARB_RR_EN
  always_comb begin
    grant_owner = OWN_CPU;
    if (cpu_req && dbg_req) begin
      grant_owner = ~last_grant;
    end else if (dbg_req) begin
      grant_owner = OWN_DBG;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Debug/loader traffic always beats the CPU.
  always_comb begin
    grant_owner = OWN_CPU;
    if (dbg_req) begin
      grant_owner = OWN_DBG;
    end
  end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - data-memory arbiter/sequencer for CPU and debug ports
// Define DM_ARB_RR_EN for round-robin tie-break; otherwise debug has fixed priority.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input logic          clk,
  input logic          rst_n,
  dm_arbiter_if.slave  bus
);

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic              owner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [2:0]        lat_type;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic grant_valid;
  logic grant_owner;
  logic last_grant;
  logic in_access;
  logic grant_now;

  assign grant_now = (state == ST_IDLE) && grant_valid;

`ifdef DM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= OWN_DBG;
    end else if (grant_now) begin
      last_grant <= grant_owner;
    end
  end
`else
  assign last_grant = OWN_DBG;
`endif

  dm_arb_pick u_pick (
    .cpu_req     (bus.cpu_req),
    .dbg_req     (bus.dbg_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (grant_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: if (cnt == LAT_LAST) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= OWN_CPU;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_type    <= DM_WORD;
      cnt         <= 4'd0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant_now) begin
        owner     <= grant_owner;
        cnt       <= 4'd0;
        lat_we    <= (grant_owner == OWN_DBG) ? bus.dbg_we    : bus.cpu_we;
        lat_addr  <= (grant_owner == OWN_DBG) ? bus.dbg_addr  : bus.cpu_addr;
        lat_wdata <= (grant_owner == OWN_DBG) ? bus.dbg_wdata : bus.cpu_wdata;
        lat_type  <= (grant_owner == OWN_DBG) ? DM_WORD       : bus.cpu_type;
      end
      // The counter parks at its last value, so it cannot wrap for any legal latency.
      if (state == ST_ACCESS) begin
        if (cnt == LAT_LAST) begin
          if (owner == OWN_DBG) dbg_rdata_q <= bus.mem_rdata;
          else                  cpu_rdata_q <= bus.mem_rdata;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

  assign in_access     = (state == ST_ACCESS);
  assign bus.mem_en    = in_access && (cnt == 4'd0);
  assign bus.mem_we    = in_access && lat_we;
  assign bus.mem_addr  = in_access ? lat_addr  : '0;
  assign bus.mem_wdata = in_access ? lat_wdata : '0;
  assign bus.mem_type  = in_access ? lat_type  : 3'b000;

  assign bus.cpu_stall = bus.cpu_req && !((state == ST_RESP) && (owner == OWN_CPU));
  assign bus.dbg_ack   = (state == ST_RESP) && (owner == OWN_DBG);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;

endmodule
